// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared constants and FSM state encoding for bus_arbiter
package bus_pkg;

   localparam int FRAME_BITS = 76;
   localparam int ADDR_W     = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      GAP  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick: first requester after owner, wrapping to 0
module rr_picker
   import bus_pkg::*;
#(
   parameter int NUM_NODES = 4
) (
   input  logic [NUM_NODES-1:0] req,
   input  logic [ADDR_W-1:0]    owner,
   output logic                 valid,
   output logic [ADDR_W-1:0]    index
);

   logic              hi_found;
   logic              lo_found;
   logic [ADDR_W-1:0] hi_idx;
   logic [ADDR_W-1:0] lo_idx;

   // Descending scan so the lowest index in each half wins; the half above owner has priority.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int j = NUM_NODES - 1; j >= 0; j--) begin
         if (req[j]) begin
            if (ADDR_W'(j) > owner) begin
               hi_found = 1'b1;
               hi_idx   = ADDR_W'(j);
            end else begin
               lo_found = 1'b1;
               lo_idx   = ADDR_W'(j);
            end
         end
      end
      valid = hi_found | lo_found;
      index = hi_found ? hi_idx : lo_idx;
   end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin single-bus arbiter (IDLE/BUSY/GAP)
// Optional tenure timeout enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int NUM_NODES      = 4,
   parameter int TIMEOUT_CYCLES = 96
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_NODES-1:0] req,
   input  logic [NUM_NODES-1:0] done,
   output logic [NUM_NODES-1:0] grant,
   output logic                 isFree,
   output logic [ADDR_W-1:0]    owner,
   output logic                 timeout_err
);

   localparam logic [ADDR_W-1:0] OWNER_RST = ADDR_W'(NUM_NODES - 1);

   if (NUM_NODES < 2 || NUM_NODES > 16 || TIMEOUT_CYCLES <= FRAME_BITS) begin : g_bad_cfg
      $error("bus_arbiter: unsupported NUM_NODES or TIMEOUT_CYCLES");
   end

   arb_state_e             state_q, state_d;
   logic [NUM_NODES-1:0]   grant_q, grant_d;
   logic                   is_free_q, is_free_d;
   logic [ADDR_W-1:0]      owner_q, owner_d;
   logic                   pick_valid;
   logic [ADDR_W-1:0]      pick_idx;
   logic                   release_own;

`ifdef BUS_ARBITER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_err_q, timeout_err_d;
`endif

   rr_picker #(
      .NUM_NODES (NUM_NODES)
   ) u_picker (
      .req   (req),
      .owner (owner_q),
      .valid (pick_valid),
      .index (pick_idx)
   );

   // grant_q is one-hot in BUSY, so masking with it selects the owner's lines.
   assign release_own = (|(done & grant_q)) | ~(|(req & grant_q));

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      is_free_d = is_free_q;
      owner_d   = owner_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
      cnt_d         = cnt_q;
      timeout_err_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            grant_d   = '0;
            is_free_d = 1'b1;
            if (pick_valid) begin
               state_d   = BUSY;
               is_free_d = 1'b0;
               owner_d   = pick_idx;
               for (int j = 0; j < NUM_NODES; j++) begin
                  grant_d[j] = (ADDR_W'(j) == pick_idx);
               end
`ifdef BUS_ARBITER_TIMEOUT_EN
               cnt_d = '0;
`endif
            end
         end
         BUSY: begin
            if (release_own) begin
               state_d = GAP;
               grant_d = '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
            end else if (cnt_q == CNT_MAX) begin
               state_d       = GAP;
               grant_d       = '0;
               timeout_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         GAP: begin
            state_d   = IDLE;
            grant_d   = '0;
            is_free_d = 1'b1;
         end
         default: begin
            state_d   = IDLE;
            grant_d   = '0;
            is_free_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         is_free_q <= 1'b1;
         owner_q   <= OWNER_RST;
`ifdef BUS_ARBITER_TIMEOUT_EN
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         is_free_q <= is_free_d;
         owner_q   <= owner_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_err_d;
`endif
      end
   end

   assign grant  = grant_q;
   assign isFree = is_free_q;
   assign owner  = owner_q;

`ifdef BUS_ARBITER_TIMEOUT_EN
   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_NODES, default 4, meaning number of nodes sharing main_bus (2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 96, meaning max bus tenure in clock cycles (76-bit frame plus margin).
REQ-003 SHALL have port clock, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port req, input, NUM_NODES, meaning per-node bus request, level, held until granted.
REQ-006 SHALL have port done, input, NUM_NODES, meaning per-node one-cycle end-of-frame pulse.
REQ-007 SHALL have port grant, output, NUM_NODES, meaning registered one-hot bus ownership.
REQ-008 SHALL have port isFree, output, 1, meaning registered bus-idle flag seen by all nodes.
REQ-009 SHALL have port owner, output, 4, meaning registered address of current/last owner.
REQ-010 SHALL have port timeout_err, output, 1, meaning one-cycle pulse on forced release.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, GAP.
REQ-012 SHALL, in IDLE with req nonzero, select the first requester scanning from owner+1 upward with wrap to 0, and enter BUSY next edge.
REQ-013 SHALL, on that edge, set grant one-hot to the winner, owner to its index, isFree to 0, and clear the tenure counter (request-to-grant latency 1 cycle).
REQ-014 SHALL, in IDLE with req zero, hold grant 0, isFree 1, and owner unchanged.
REQ-015 SHALL, in BUSY, increment the tenure counter each cycle, saturating at TIMEOUT_CYCLES-1.
REQ-016 SHALL, in BUSY, on done[owner]=1 or req[owner]=0, enter GAP and clear grant.
REQ-017 SHALL ignore done pulses from non-owners.
REQ-018 SHALL hold GAP exactly one cycle with grant 0 and isFree 0, then enter IDLE with isFree 1.
REQ-019 SHALL never assert more than one grant bit, nor grant and isFree together.
REQ-020 SHALL let a node re-win only after all other pending requesters have been served (round-robin fairness).

Reset
REQ-021 SHALL, on reset assertion and regardless of clock, force state IDLE, grant 0, isFree 1, owner NUM_NODES-1, counter 0, and timeout_err 0.
REQ-022 SHALL drop any in-progress tenure on reset mid-BUSY, without pulsing timeout_err.
REQ-023 SHALL give node 0 first priority after reset, because owner resets to NUM_NODES-1.

Configuration
REQ-024 SHALL, with macro BUS_ARBITER_TIMEOUT_EN defined, in BUSY with counter equal to TIMEOUT_CYCLES-1 and no release, enter GAP, clear grant, and pulse timeout_err for one cycle.
REQ-025 SHALL, when done and timeout coincide, treat the release as normal and not pulse timeout_err.
REQ-026 SHALL, without BUS_ARBITER_TIMEOUT_EN, hold the bus until release only, tie timeout_err to 0, and omit the counter.

Structure
REQ-027 SHALL take the state encoding, FRAME_BITS=76, and ADDR_W=4 constants from shared package bus_pkg.
REQ-028 SHALL place the round-robin selection in combinational sub-module rr_picker (inputs req and owner; outputs valid and index).

Verification
REQ-029 SHALL test: reset, then req=0001 -> grant=0001, owner=0, and isFree=0 one cycle after the request is sampled.
REQ-030 SHALL test: req=1111 held, with each owner pulsing done after 10 cycles -> grant sequence 0001, 0010, 0100, 1000, 0001, each separated by a one-cycle GAP.
REQ-031 SHALL test: owner 2 with done[1] pulsed -> no effect; then done[2] -> grant 0 next cycle and isFree 1 one cycle later.
REQ-032 SHALL test, with BUS_ARBITER_TIMEOUT_EN defined: owner never pulses done -> timeout_err pulse at tenure cycle 96, then grant 0; without the macro, grant is held for 200 cycles.
REQ-033 SHALL test: done[owner] on cycle 96 -> release with timeout_err remaining 0.
REQ-034 SHALL test: reset asserted mid-BUSY between clock edges -> grant 0, isFree 1 immediately; after release, req=1010 -> grant=0010.
